compare_scheduler: RTL and testbench
====================================

COMPARE_SCHEDULER -- requirements
Module: compare_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: req  input  2  per-requester level request; bit i = requester i.
REQ-004 SHALL have ports: a0, b0, a1, b1  input  32 each  unsigned operands of requester 0 and requester 1.
REQ-005 SHALL have port: busy  output  1  high while a comparison is in progress or completing.
REQ-006 SHALL have port: grant_id  output  1  requester currently or last served.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-008 SHALL have ports: L, E, G  output  1 each  registered result (a<b, a==b, a>b).

Function
REQ-009 SHALL implement FSM states IDLE, RUN and DONE; transitions IDLE->RUN (any req bit high), RUN->DONE (scan complete), DONE->IDLE (unconditional).
REQ-010 SHALL, in IDLE with req!=0, grant one requester at that edge (grant edge), copy its a/b into internal 32-bit shift registers, set bit counter to 31 and enter RUN.
REQ-011 SHALL arbitrate round-robin: both requesting -> the requester not granted last wins; after reset requester 0 has priority.
REQ-012 SHALL, each RUN cycle, compare the current MSBs of the shift registers, shift both left by one and decrement the counter; the first differing bit latches G (a bit 1) or L (b bit 1); later bits SHALL be ignored.
REQ-013 SHALL leave RUN at the edge where the counter equals 0, i.e. 32 RUN cycles; done SHALL be high exactly in the cycle following edge 32 after the grant edge.
REQ-014 SHALL update L/E/G on the RUN->DONE edge: exactly one high; E=1 when no bit differed; values held until the next RUN->DONE edge.
REQ-015 SHALL hold busy high in RUN and DONE and low in IDLE; grant_id updates only on a grant edge.
REQ-016 SHALL ignore req changes and operand changes after the grant edge; the comparison completes with captured operands even if req drops.
REQ-017 SHALL not grant during DONE; a request pending at DONE is granted at the following IDLE edge (one idle cycle between back-to-back jobs).
REQ-018 SHALL treat a requester holding req high after done as a new request, subject to REQ-011.

Reset
REQ-019 SHALL, while reset=0, force state IDLE, busy=0, done=0, L=E=G=0, grant_id=0, counter=0, shift registers=0, round-robin pointer to requester-0 priority, independent of clk.
REQ-020 SHALL, on reset assertion mid-RUN or in DONE, abort the job with no done pulse; first grant after release follows REQ-011 reset priority.

Configuration
REQ-021 SHALL support macro COMPARE_SCHEDULER_EARLY_EXIT_EN.
REQ-022 SHALL, with COMPARE_SCHEDULER_EARLY_EXIT_EN defined, leave RUN at the edge where the first differing bit is found: difference at bit k -> done in the cycle following edge 32-k after the grant edge; equal operands still take 32 RUN cycles.
REQ-023 SHALL, without the macro, always take 32 RUN cycles per REQ-013; L/E/G values are identical in both builds.

Verification
REQ-024 SHALL cover: req=01, a0=50, b0=50 -> grant_id=0, busy 1, done in cycle after edge 32, E=1, L=G=0.
REQ-025 SHALL cover: req=10, a1=0x80000000, b1=0x7FFFFFFF -> G=1, grant_id=1; done after edge 32 (macro off) or edge 1 (macro on).
REQ-026 SHALL cover: req=01, a0=1, b0=2 -> L=1; done after edge 32 (macro off) or edge 31 (macro on).
REQ-027 SHALL cover: req=11 held continuously after reset -> grants 0,1,0,1; each done followed by one IDLE cycle before next grant.
REQ-028 SHALL cover: reset driven 0 at RUN cycle 10 -> busy, done, L, E, G drop to 0 immediately; no done pulse; after release req=11 -> requester 0 granted.
REQ-029 SHALL cover: req=01 dropped and a0 changed to 0 one cycle after grant, a0=7, b0=3 captured -> done after edge 32 (macro off), G=1.

Source files
------------

// File: rtl/compare_scheduler.sv
// -----------------------------------------------------------------------------
// compare_scheduler
//
// Purpose:
//   Two-requester, round-robin scheduled, bit-serial unsigned magnitude
//   comparator. A granted requester's 32-bit operands are captured into
//   internal shift registers and compared MSB-first, one bit per clock.
//   The first differing bit decides the result; later bits are ignored.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   reset      in   1   asynchronous active-low reset (0 = in reset)
//   req        in   2   level requests, bit i = requester i
//   a0, b0     in  32   operands of requester 0
//   a1, b1     in  32   operands of requester 1
//   busy       out  1   high in RUN and DONE
//   grant_id   out  1   requester currently or last served
//   done       out  1   one-cycle pulse, result valid
//   L, E, G    out  1   registered result a<b, a==b, a>b (exactly one high
//                       after the first completed job, all low after reset)
//   state_dbg  out  2   current FSM state encoding (0 IDLE, 1 RUN, 2 DONE)
//
// Build option:
//   COMPARE_SCHEDULER_EARLY_EXIT_EN - when defined, RUN ends at the cycle the
//   first differing bit is found instead of always scanning all 32 bits.
//   Results are identical in both builds; only the latency changes.
//
// Handshake: req is a level request sampled only in IDLE. The job is fixed
// at the grant edge; later req/operand changes do not affect it. done pulses
// for exactly one cycle (the DONE state) and no grant happens during DONE.
// -----------------------------------------------------------------------------
module compare_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        busy,
  output logic        grant_id,
  output logic        done,
  output logic        L,
  output logic        E,
  output logic        G,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sa_q, sa_d;        // operand a shift register
  logic [31:0] sb_q, sb_d;        // operand b shift register
  logic [4:0]  cnt_q, cnt_d;      // index of the bit currently at the MSB
  logic        grant_id_q, grant_id_d;
  logic        prio_q, prio_d;    // requester that wins when both request
  logic        found_q, found_d;  // a differing bit has already been seen
  logic        lt_q, lt_d;        // a<b at the first differing bit
  logic        l_q, l_d;
  logic        e_q, e_d;
  logic        g_q, g_d;

  logic        diff;
  logic        first_diff;
  logic        finish;
  logic        gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sa_q       <= 32'd0;
      sb_q       <= 32'd0;
      cnt_q      <= 5'd0;
      grant_id_q <= 1'b0;
      prio_q     <= 1'b0;
      found_q    <= 1'b0;
      lt_q       <= 1'b0;
      l_q        <= 1'b0;
      e_q        <= 1'b0;
      g_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      grant_id_q <= grant_id_d;
      prio_q     <= prio_d;
      found_q    <= found_d;
      lt_q       <= lt_d;
      l_q        <= l_d;
      e_q        <= e_d;
      g_q        <= g_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    cnt_d      = cnt_q;
    grant_id_d = grant_id_q;
    prio_d     = prio_q;
    found_d    = found_q;
    lt_d       = lt_q;
    l_d        = l_q;
    e_d        = e_q;
    g_d        = g_q;

    diff       = sa_q[31] ^ sb_q[31];
    first_diff = diff & ~found_q;
    finish     = 1'b0;
    gnt        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Single requester wins outright; on contention the priority
          // pointer decides and then moves to the other requester.
          gnt        = (req == 2'b11) ? prio_q : req[1];
          grant_id_d = gnt;
          prio_d     = ~gnt;
          sa_d       = gnt ? a1 : a0;
          sb_d       = gnt ? b1 : b0;
          cnt_d      = 5'd31;
          found_d    = 1'b0;
          lt_d       = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        sa_d = {sa_q[30:0], 1'b0};
        sb_d = {sb_q[30:0], 1'b0};
        if (first_diff) begin
          found_d = 1'b1;
          lt_d    = sb_q[31];
        end
`ifdef COMPARE_SCHEDULER_EARLY_EXIT_EN
        finish = (cnt_q == 5'd0) | first_diff;
`else
        finish = (cnt_q == 5'd0);
`endif
        if (finish) begin
          // The bit compared in this final cycle is folded in directly,
          // since found_q/lt_q only reflect earlier cycles.
          cnt_d   = 5'd0;
          state_d = S_DONE;
          if (found_q) begin
            l_d = lt_q;
            e_d = 1'b0;
            g_d = ~lt_q;
          end else if (diff) begin
            l_d = sb_q[31];
            e_d = 1'b0;
            g_d = sa_q[31];
          end else begin
            l_d = 1'b0;
            e_d = 1'b1;
            g_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign grant_id  = grant_id_q;
  assign L         = l_q;
  assign E         = e_q;
  assign G         = g_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_compare_scheduler.sv
// -----------------------------------------------------------------------------
// tb_compare_scheduler
//
// Directed-vector bench for compare_scheduler. Expected grant ids, results
// and latencies are hand-computed constants; results are queued in exp_q
// when a job starts and popped when its done pulse is seen.
// -----------------------------------------------------------------------------
module tb_compare_scheduler;

`ifdef COMPARE_SCHEDULER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] a0, b0, a1, b1;
  logic        busy, grant_id, done, L, E, G;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  compare_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done),
    .L         (L),
    .E         (E),
    .G         (G),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [2:0] exp_q[$];   // expected {L,E,G} per job in order

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  // Drive a request at the falling edge; return #1 after the grant edge.
  task automatic start_job(input logic [1:0] r, input logic [31:0] x0,
                           input logic [31:0] y0, input logic [31:0] x1,
                           input logic [31:0] y1, input bit hold_req);
    @(negedge clk);
    req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    @(posedge clk);
    #1;
    if (!hold_req) req = 2'b00;
  endtask

  // Count rising edges until done is seen (0 = not seen within max_edges).
  task automatic wait_done(input int max_edges, output int n);
    n = 0;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_leg"}, {29'd0, L, E, G}, {29'd0, e});
    end
  endtask

  // Complete single job from idle, checking grant, latency, result, and that
  // done is a one-cycle pulse followed by IDLE.
  task automatic do_job(input string tag, input logic [1:0] r,
                        input logic [31:0] x0, input logic [31:0] y0,
                        input logic [31:0] x1, input logic [31:0] y1,
                        input logic exp_id, input logic [2:0] exp_leg,
                        input int exp_lat);
    int n;
    exp_q.push_back(exp_leg);
    start_job(r, x0, y0, x1, y1, 1'b0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_gid"}, {31'd0, grant_id}, {31'd0, exp_id});
    wait_done(40, n);
    check_eq({tag, "_lat"}, n, exp_lat);
    check_result(tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    reset = 1'b0;
    req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_leg", {29'd0, L, E, G}, 32'd0);
    check_eq("rst_gid", {31'd0, grant_id}, 32'd0);
    check_eq("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // equal operands: always full 32-cycle scan
    do_job("eq50", 2'b01, 32'd50, 32'd50, 32'd0, 32'd0, 1'b0, 3'b010, 32);
    // difference at bit 31
    do_job("msb", 2'b10, 32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF,
           1'b1, 3'b001, EE ? 1 : 32);
    // difference at bit 1, bit 0 also differs but must be ignored
    do_job("lt12", 2'b01, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 3'b100,
           EE ? 31 : 32);
    // a=0xFFFFFFFE, b=0xFFFFFFFF: difference only at bit 0
    do_job("lsb", 2'b10, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
           1'b1, 3'b100, 32);

    // captured operands survive req drop and operand change after grant
    exp_q.push_back(3'b001);
    start_job(2'b01, 32'd7, 32'd3, 32'd0, 32'd0, 1'b1);
    check_eq("cap_gid", {31'd0, grant_id}, 32'd0);
    @(posedge clk);
    #1;
    req = 2'b00; a0 = 32'd0;
    check_eq("cap_held_leg", {29'd0, L, E, G}, 32'b100);
    wait_done(40, n);
    check_eq("cap_lat", (n == 0) ? 0 : n + 1, EE ? 30 : 32);
    check_result("cap");
    @(posedge clk);
    #1;

    // contention from reset: grants alternate 0,1,0,1 with one idle cycle
    @(negedge clk);
    reset = 1'b0;
    a0 = 32'd5; b0 = 32'd9; a1 = 32'd9; b1 = 32'd5;
    req = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rr_first_busy", {31'd0, busy}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back((j % 2 == 0) ? 3'b100 : 3'b001);
      check_eq($sformatf("rr%0d_gid", j), {31'd0, grant_id}, j % 2);
      wait_done(40, n);
      check_eq($sformatf("rr%0d_lat", j), n, EE ? 29 : 32);
      check_result($sformatf("rr%0d", j));
      @(posedge clk);
      #1;
      check_eq($sformatf("rr%0d_gap", j), {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check_eq($sformatf("rr%0d_regrant", j), {31'd0, busy}, 32'd1);
    end
    req = 2'b00;
    exp_q.push_back(3'b100);
    wait_done(40, n);
    check_eq("rr_tail_lat", n, EE ? 29 : 32);
    check_result("rr_tail");
    @(posedge clk);
    #1;

    // abort mid-RUN: requester 0 served so pointer favours 1, then reset
    start_job(2'b01, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_leg", {29'd0, L, E, G}, 32'd0);
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check_eq("abort_no_done", n, 0);
    do_job("post_abort", 2'b11, 32'd3, 32'd4, 32'd4, 32'd3, 1'b0, 3'b100,
           EE ? 30 : 32);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
